conv_window_gen: RTL and testbench

Streaming 3×3 window generator that sits directly upstream of `conv2d_serial`. It accepts a raster-order pixel stream and buffers the two previous image rows in line buffers. For every valid (unpadded) 3×3 neighbourhood it presents the nine window pixels on `win0..win8`, pulses `conv_start`, and then stalls the pixel stream until the convolution stage reports `conv_done`. It produces (IMG_W−2)×(IMG_H−2) windows per frame.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_line_buffer.sv | 29 ++
 rtl/conv_window_gen.sv | 166 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks: data width default,
// window-generator FSM states and 3x3 window index constants.
package cnn_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int WIN_TL = 0;
  localparam int WIN_C  = 4;
  localparam int WIN_BR = 8;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2
  } win_state_e;

endpackage

// File: rtl/cnn_line_buffer.sv
// Two-row line buffer sharing one column address; reads are combinational
// and a write shifts row0 into row1 at that column (read-before-write).
module cnn_line_buffer #(
  parameter int IMG_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(IMG_W)-1:0] addr_i,
  input  logic [DATA_W-1:0]        din_i,
  output logic [DATA_W-1:0]        lb0_o,
  output logic [DATA_W-1:0]        lb1_o
);

  logic [DATA_W-1:0] row0_q [IMG_W];
  logic [DATA_W-1:0] row1_q [IMG_W];

  assign lb0_o = row0_q[addr_i];
  assign lb1_o = row1_q[addr_i];

  // Contents are deliberately not reset: rows 0-1 of every frame refill them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      row1_q[addr_i] <= row0_q[addr_i];
      row0_q[addr_i] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: buffers two rows, issues each fully valid
// window to the serial conv stage and stalls the pixel stream until it is done.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [DATA_W-1:0]        win0,
  output logic [DATA_W-1:0]        win1,
  output logic [DATA_W-1:0]        win2,
  output logic [DATA_W-1:0]        win3,
  output logic [DATA_W-1:0]        win4,
  output logic [DATA_W-1:0]        win5,
  output logic [DATA_W-1:0]        win6,
  output logic [DATA_W-1:0]        win7,
  output logic [DATA_W-1:0]        win8,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
  output logic                     conv_start,
  input  logic                     conv_done,
  output logic                     frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  win_state_e        state_q, state_d;
  logic [XW-1:0]     c_q, c_d, win_x_q, win_x_d;
  logic [YW-1:0]     r_q, r_d, win_y_q, win_y_d;
  logic              last_q, last_d;
  logic              wait_seen_q, wait_seen_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] lb0_s, lb1_s;
  logic              xfer_s, win_hit_s, last_hit_s;

  assign pix_ready  = (state_q == ACCEPT) && !rst;
  assign xfer_s     = pix_valid && pix_ready;
  assign conv_start = (state_q == ISSUE);
  assign frame_done = frame_done_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign win_hit_s  = (r_q >= YW'(2)) && (c_q >= XW'(2));
  assign last_hit_s = (r_q == YW'(IMG_H - 1)) && (c_q == XW'(IMG_W - 1));

  assign win0 = win_q[WIN_TL];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[WIN_C];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[WIN_BR];

  cnn_line_buffer #(
    .IMG_W  (IMG_W),
    .DATA_W (DATA_W)
  ) u_lb (
    .clk    (clk),
    .we_i   (xfer_s),
    .addr_i (c_q),
    .din_i  (pix_in),
    .lb0_o  (lb0_s),
    .lb1_o  (lb1_s)
  );

  // Next-state logic: raster counters, window latch and the WAIT handshake.
  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    r_d          = r_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    last_d       = last_q;
    wait_seen_d  = (state_q == WAIT);
    frame_done_d = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (xfer_s) begin
          if (c_q == XW'(IMG_W - 1)) begin
            c_d = '0;
            r_d = (r_q == YW'(IMG_H - 1)) ? '0 : r_q + YW'(1);
          end else begin
            c_d = c_q + XW'(1);
          end
          if (win_hit_s) begin
            win_x_d = c_q - XW'(2);
            win_y_d = r_q - YW'(2);
            last_d  = last_hit_s;
            state_d = ISSUE;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          state_d = ACCEPT;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A done seen in the first WAIT cycle belongs to the previous window.
        if (wait_seen_q && conv_done) begin
          state_d = ACCEPT;
          if (last_q) begin
            frame_done_d = 1'b1;
            r_d          = '0;
            c_d          = '0;
          end else begin
            frame_done_d = 1'b0;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACCEPT;
      c_q          <= '0;
      r_q          <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      last_q       <= 1'b0;
      wait_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      r_q          <= r_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      last_q       <= last_d;
      wait_seen_q  <= wait_seen_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window shift register: each accepted pixel pushes a new right column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else if (xfer_s) begin
      win_q[0]      <= win_q[1];
      win_q[1]      <= win_q[2];
      win_q[2]      <= lb1_s;
      win_q[3]      <= win_q[4];
      win_q[4]      <= win_q[5];
      win_q[5]      <= lb0_s;
      win_q[6]      <= win_q[7];
      win_q[7]      <= win_q[WIN_BR];
      win_q[WIN_BR] <= pix_in;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 5x5 image with a serial conv
// stage model; windows are predicted directly from the pixel raster.
module tb_conv_window_gen;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          conv_start;
  logic          conv_done = 1'b0;
  logic          frame_done;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
    .win5(win5), .win6(win6), .win7(win7), .win8(win8),
    .win_x(win_x), .win_y(win_y), .conv_start(conv_start),
    .conv_done(conv_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px[9];
    int x;
    int y;
  } win_t;

  int     checks = 0;
  int     errors = 0;
  win_t   exp_q[$];
  win_t   cur, cap, held, first_w, last_w;
  logic [DW-1:0] dut_w [9];
  int     win_in_frame = 0;
  int     fd_count = 0;
  int     low_cnt = 0;
  bit     pending = 1'b0;
  bit     hold_done = 1'b0;
  bit     done_at_edge = 1'b0;
  bit     ok;
  int     ccnt = 0;

  always_comb begin
    dut_w[0] = win0; dut_w[1] = win1; dut_w[2] = win2;
    dut_w[3] = win3; dut_w[4] = win4; dut_w[5] = win5;
    dut_w[6] = win6; dut_w[7] = win7; dut_w[8] = win8;
  end

  // Serial conv stage: done one cycle wide, 9 cycles after start, or stuck high.
  always @(negedge clk) begin
    if (hold_done) conv_done = 1'b1;
    else if (rst) begin ccnt = 0; conv_done = 1'b0; end
    else if (conv_start) begin ccnt = 9; conv_done = 1'b0; end
    else if (ccnt > 0) begin ccnt = ccnt - 1; conv_done = (ccnt == 0); end
    else conv_done = 1'b0;
  end

  always @(posedge clk) done_at_edge = conv_done;

  // Expected windows straight from the raster: pixel(r,c) = base + r*W + c.
  task automatic push_frame(input int base);
    win_t w;
    for (int y = 0; y < H - 2; y++)
      for (int x = 0; x < W - 2; x++) begin
        for (int k = 0; k < 9; k++) w.px[k] = base + (y + k / 3) * W + (x + k % 3);
        w.x = x;
        w.y = y;
        exp_q.push_back(w);
      end
  endtask

  // Compare process: window contents at issue, stability and stall length.
  always @(negedge clk) begin
    if (rst) begin
      win_in_frame = 0;
      pending = 1'b0;
    end else begin
      for (int k = 0; k < 9; k++) cap.px[k] = int'(dut_w[k]);
      cap.x = int'(win_x);
      cap.y = int'(win_y);
      if (conv_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got window x=%0d y=%0d, required no window", cap.x, cap.y);
        end else begin
          cur = exp_q.pop_front();
          ok = (cap.x == cur.x) && (cap.y == cur.y);
          for (int k = 0; k < 9; k++) if (cap.px[k] != cur.px[k]) ok = 1'b0;
          if (!ok) begin
            errors++;
            $display("FAIL window(%0d,%0d): got %p x=%0d y=%0d, required %p", cur.x, cur.y,
                     cap.px, cap.x, cap.y, cur.px);
          end
        end
        if (win_in_frame == 0) first_w = cap;
        last_w = cap;
        held = cap;
        win_in_frame++;
        pending = 1'b1;
        low_cnt = 1;
      end else if (pending) begin
        checks++;
        if (!pix_ready) begin
          low_cnt++;
          ok = (cap.x == held.x) && (cap.y == held.y);
          for (int k = 0; k < 9; k++) if (cap.px[k] != held.px[k]) ok = 1'b0;
          if (!ok) begin
            errors++;
            $display("FAIL win_stable: got %p, required %p", cap.px, held.px);
          end
        end else begin
          if (low_cnt != (hold_done ? 3 : 10)) begin
            errors++;
            $display("FAIL stall_len: got %0d cycles, required %0d", low_cnt, hold_done ? 3 : 10);
          end
          pending = 1'b0;
        end
      end
      if (frame_done) begin
        checks++;
        if (win_in_frame != 9 || !pix_ready || !done_at_edge) begin
          errors++;
          $display("FAIL frame_done_point: got windows=%0d ready=%0b done=%0b, required 9 1 1",
                   win_in_frame, pix_ready, done_at_edge);
        end
        fd_count++;
        win_in_frame = 0;
      end
    end
  end

  // Called at posedge+1; advances only on an observed transfer.
  task automatic send_pixels(input int base, input int n, input bit gaps);
    int  idx = 0;
    int  guard = 0;
    bit  xfer;
    while (idx < n && guard < 2000) begin
      pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_in    = pix_valid ? DW'(base + idx) : 8'hEE;
      @(negedge clk);
      xfer = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL send_timeout: got %0d pixels accepted, required %0d", idx, n);
    end
  endtask

  task automatic wait_frame(input int fd_before);
    int g = 0;
    while (fd_count == fd_before && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (fd_count != fd_before + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_end: got frame_done=%0d windows_left=%0d, required 1 0",
               fd_count - fd_before, exp_q.size());
    end
  endtask

  task automatic check_lit(input string name, input win_t got, input int lit[9],
                           input int x, input int y);
    bit good;
    good = (got.x == x) && (got.y == y);
    for (int k = 0; k < 9; k++) if (got.px[k] != lit[k]) good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL %s: got %p x=%0d y=%0d, required %p x=%0d y=%0d",
               name, got.px, got.x, got.y, lit, x, y);
    end
  endtask

  task automatic check_reset_vals(input string name);
    bit good;
    good = !pix_ready && !conv_start && !frame_done && (win_x == '0) && (win_y == '0);
    for (int k = 0; k < 9; k++) if (dut_w[k] != '0) good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL %s: got ready=%0b start=%0b fdone=%0b w0=%0d w8=%0d x=%0d y=%0d, required all 0",
               name, pix_ready, conv_start, frame_done, win0, win8, win_x, win_y);
    end
  endtask

  task automatic release_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got pix_ready=%0b, required 1", name, pix_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int base, input bit gaps);
    int fd0;
    fd0 = fd_count;
    push_frame(base);
    send_pixels(base, W * H, gaps);
    wait_frame(fd0);
  endtask

  int lit_first[9], lit_last[9], lit_second[9];

  initial begin
    lit_first  = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    lit_last   = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    lit_second = '{101, 102, 103, 106, 107, 108, 111, 112, 113};

    @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_vals");
    release_reset("ready_after_reset");

    run_frame(1, 1'b0);
    check_lit("first_win", first_w, lit_first, 0, 0);
    check_lit("last_win", last_w, lit_last, 2, 2);

    run_frame(101, 1'b1);
    check_lit("second_frame_first", first_w, lit_second, 0, 0);

    hold_done = 1'b1;
    run_frame(51, 1'b0);
    hold_done = 1'b0;
    @(posedge clk); #1;

    send_pixels(1, 12, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midframe_reset_vals");
    release_reset("ready_after_midreset");

    run_frame(1, 1'b0);
    check_lit("post_reset_first", first_w, lit_first, 0, 0);
    check_lit("post_reset_last", last_w, lit_last, 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
